// File: rtl/rv32_types.sv
// Shared types for the rv32 pipeline control slice.
// Sequencer states, per-stage control bundle and mul/div latency default.
package rv32_types;

  localparam int MD_LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MD_BUSY
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic fetch_en;
    logic decode_en;
    logic exec_en;
    logic mem_en;
    logic wb_en;
    logic flush_fetch_buff;
    logic flush_decoded_buff;
    logic pc_redirect;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE = '0;
  localparam pipe_ctrl_t CTRL_ADVANCE = 8'b11111_000;

  // Branch beats the load-use stall: the stalled instruction is wrong-path.
  function automatic pipe_ctrl_t run_ctrl(input logic branch,
                                          input logic hazard);
    pipe_ctrl_t c;
    c = CTRL_ADVANCE;
    if (branch) begin
      c.flush_fetch_buff   = 1'b1;
      c.flush_decoded_buff = 1'b1;
      c.pc_redirect        = 1'b1;
    end else if (hazard) begin
      c.fetch_en           = 1'b0;
      c.decode_en          = 1'b0;
      c.flush_decoded_buff = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/rv32_perf_counter.sv
// Free-running wrap-around event counter.
// Synchronous clear, increments by one on each qualifying cycle.
module rv32_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/rv32_pipeline_control_unit.sv
// Central 5-stage pipeline sequencer: stage enables, bubbles,
// flushes, mul/div and memory-wait freezing, stall/flush counters.
module rv32_pipeline_control_unit
  import rv32_types::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mem_req_valid,
  input  logic             mem_req_ready,
  input  logic             muldiv_start,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             flush_fetch_buff,
  output logic             flush_decoded_buff,
  output logic             pc_redirect,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int MDW = $clog2(MD_LATENCY);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LATENCY - 2);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_state_nxt;
  logic [MDW-1:0]   r_md_cnt;
  logic [MDW-1:0]   w_md_cnt_nxt;
  pipe_ctrl_t       w_ctrl;
  logic             w_done;

  always_comb begin
    w_ctrl       = CTRL_FREEZE;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_done       = 1'b0;
    if (rst) begin
      w_ctrl.flush_fetch_buff   = 1'b1;
      w_ctrl.flush_decoded_buff = 1'b1;
      w_state_nxt               = RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (mem_req_valid && !mem_req_ready) begin
            w_state_nxt = MEM_WAIT;
          end else if (muldiv_start) begin
            w_md_cnt_nxt = MD_LOAD;
            w_state_nxt  = MD_BUSY;
          end else begin
            w_ctrl = run_ctrl(branch_taken, hazard_stall);
          end
        end
        MEM_WAIT: begin
          if (mem_req_ready) begin
            w_ctrl      = run_ctrl(branch_taken, hazard_stall);
            w_state_nxt = RUN;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt != '0) begin
            w_md_cnt_nxt = r_md_cnt - 1'b1;
          end else begin
            w_ctrl      = CTRL_ADVANCE;
            w_done      = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  assign fetch_en           = w_ctrl.fetch_en;
  assign decode_en          = w_ctrl.decode_en;
  assign exec_en            = w_ctrl.exec_en;
  assign mem_en             = w_ctrl.mem_en;
  assign wb_en              = w_ctrl.wb_en;
  assign flush_fetch_buff   = w_ctrl.flush_fetch_buff;
  assign flush_decoded_buff = w_ctrl.flush_decoded_buff;
  assign pc_redirect        = w_ctrl.pc_redirect;
  assign muldiv_done        = w_done;

  rv32_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (!w_ctrl.fetch_en),
    .value(stall_cycles)
  );

  rv32_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_ctrl.pc_redirect),
    .value(flush_events)
  );

endmodule

// File: tb/tb_rv32_pipeline_control_unit.sv
// Scoreboard bench for rv32_pipeline_control_unit.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_rv32_pipeline_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        muldiv_start = 1'b0;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        flush_fetch_buff, flush_decoded_buff;
  logic        pc_redirect, muldiv_done;
  logic [31:0] stall_cycles, flush_events;

  typedef struct packed {
    logic [4:0]  en;
    logic        ff;
    logic        fd;
    logic        pr;
    logic        md;
    logic [31:0] s;
    logic [31:0] f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  rv32_pipeline_control_unit #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .hazard_stall      (hazard_stall),
    .branch_taken      (branch_taken),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .muldiv_start      (muldiv_start),
    .fetch_en          (fetch_en),
    .decode_en         (decode_en),
    .exec_en           (exec_en),
    .mem_en            (mem_en),
    .wb_en             (wb_en),
    .flush_fetch_buff  (flush_fetch_buff),
    .flush_decoded_buff(flush_decoded_buff),
    .pc_redirect       (pc_redirect),
    .muldiv_done       (muldiv_done),
    .stall_cycles      (stall_cycles),
    .flush_events      (flush_events)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the DUT must show in it.
  task automatic step(input logic r, h, b, v, y, m,
                      input logic [4:0] en,
                      input logic ff, fd, pr, md,
                      input int s, f);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    hazard_stall = h;
    branch_taken = b;
    mem_req_valid = v;
    mem_req_ready = y;
    muldiv_start = m;
    e.en = en;
    e.ff = ff;
    e.fd = fd;
    e.pr = pr;
    e.md = md;
    e.s = 32'(s);
    e.f = 32'(f);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    a_proto: assert (!(muldiv_start && branch_taken))
      else $error("protocol: muldiv_start with branch_taken");
  end

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a.en = {fetch_en, decode_en, exec_en, mem_en, wb_en};
        a.ff = flush_fetch_buff;
        a.fd = flush_decoded_buff;
        a.pr = pc_redirect;
        a.md = muldiv_done;
        a.s = stall_cycles;
        a.f = flush_events;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL vec%0d: got en=%b ff=%b fd=%b pr=%b md=%b s=%0d f=%0d, want en=%b ff=%b fd=%b pr=%b md=%b s=%0d f=%0d",
                   vec_idx, a.en, a.ff, a.fd, a.pr, a.md, a.s, a.f,
                   e.en, e.ff, e.fd, e.pr, e.md, e.s, e.f);
        end
        vec_idx++;
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    //    r  h  b  v  y  m   en        ff fd pr md  s   f
    step(1, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 0,  0, 0);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  0, 0);
    step(0, 1, 0, 0, 0, 0, 5'b00111, 0, 1, 0, 0,  0, 0);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  1, 0);
    step(0, 1, 1, 0, 0, 0, 5'b11111, 1, 1, 1, 0,  1, 0);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  1, 1);
    step(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0,  1, 1);
    step(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0,  2, 1);
    step(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0,  3, 1);
    step(0, 0, 0, 1, 1, 0, 5'b11111, 0, 0, 0, 0,  4, 1);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  4, 1);
    step(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0,  4, 1);
    step(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0,  5, 1);
    step(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0,  6, 1);
    step(0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 1,  7, 1);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  7, 1);
    step(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0,  7, 1);
    step(0, 0, 1, 1, 1, 0, 5'b11111, 1, 1, 1, 0,  8, 1);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  8, 2);
    step(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0,  8, 2);
    step(0, 1, 0, 1, 1, 1, 5'b00111, 0, 1, 0, 0,  9, 2);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 10, 2);
    step(0, 0, 0, 1, 0, 1, 5'b00000, 0, 0, 0, 0, 10, 2);
    step(0, 0, 0, 1, 1, 0, 5'b11111, 0, 0, 0, 0, 11, 2);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 11, 2);
    step(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 11, 2);
    step(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 12, 2);
    step(1, 0, 0, 0, 0, 1, 5'b00000, 1, 1, 0, 0, 13, 2);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  0, 0);
    step(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0,  0, 0);
    step(1, 0, 0, 1, 0, 0, 5'b00000, 1, 1, 0, 0,  1, 0);
    step(0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0,  0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_pipeline_control_unit.md
# rv32_pipeline_control_unit

Central pipeline sequencer for the 5-stage rv32 core. It turns the decode-stage load-use stall, the exec-stage branch redirect, the data-memory handshake and the multi-cycle mul/div unit into per-stage buffer enables and bubble/flush controls. It also keeps free-running stall and flush event counters. It sits beside the pipeline buffers and drives their write-enable and invalidate inputs.

## Interface
- MD_LATENCY, 4: cycles from mul/div start to result, inclusive; legal range 2..16.
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- hazard_stall  in  1  load-use stall from the decode-stage hazard detection unit.
- branch_taken  in  1  exec-stage instruction redirects the PC.
- mem_req_valid  in  1  mem-stage instruction issues a data-memory access.
- mem_req_ready  in  1  data memory accepts or completes the access this cycle.
- muldiv_start  in  1  exec-stage instruction is a mul/div; held while the instruction sits in exec.
- fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  write enables of the PC, fetch, decoded, exec and mem buffers.
- flush_fetch_buff  out  1  invalidate the fetch buffer (NOP).
- flush_decoded_buff  out  1  write a bubble into the decoded buffer.
- pc_redirect  out  1  select the branch target for the PC.
- muldiv_done  out  1  one-cycle pulse: the mul/div result is valid and exec advances.
- stall_cycles, flush_events  out  CNT_W  performance counters.

## Operation
- State register with states RUN, MEM_WAIT, MD_BUSY. Reset state is RUN. A down-counter md_cnt of width $clog2(MD_LATENCY) resets to 0.
- Outputs are combinational from the state and the inputs. The state, md_cnt and the counters are registered.
- While rst=1: all enables 0, both flushes 1, pc_redirect 0, muldiv_done 0, counters cleared.
- RUN evaluation uses fixed priority, highest first:
  1. mem_req_valid && !mem_req_ready: all enables 0, no flush; go to MEM_WAIT.
  2. muldiv_start: all enables 0; load md_cnt = MD_LATENCY-2; go to MD_BUSY.
  3. branch_taken: all enables 1, both flushes 1, pc_redirect 1. Branch overrides hazard_stall, because the stalled instruction is wrong-path.
  4. hazard_stall: fetch_en = decode_en = 0, flush_decoded_buff 1, exec/mem/wb enables 1.
  5. Otherwise: all enables 1, no flushes.
- MEM_WAIT:
  - If mem_req_ready=0: all enables 0.
  - If mem_req_ready=1: return to RUN. Outputs this cycle follow RUN rules 3-5; rule 1 is bypassed and rule 2 is ignored.
- MD_BUSY:
  - While md_cnt != 0: all enables 0 and md_cnt decrements.
  - When md_cnt = 0: muldiv_done 1, all enables 1, return to RUN. muldiv_start is ignored in this cycle.
  - muldiv_start is accepted only in RUN. A start held high while frozen never restarts the sequence.
- muldiv_start together with branch_taken is a protocol error. muldiv_start wins and the bench asserts on it.
- Counters wrap modulo 2^CNT_W.
  - stall_cycles increments on any cycle out of reset where fetch_en=0.
  - flush_events increments on every cycle with pc_redirect=1.

## Timing
- No latency from inputs to enables/flushes: same-cycle combinational path.
- mul/div started at cycle t: frozen during t..t+MD_LATENCY-2; muldiv_done and all enables high at t+MD_LATENCY-1.
- A load-use stall costs exactly one bubble, provided the hazard unit deasserts once the load reaches mem.
- A taken branch costs two bubbles: the fetch and decoded buffers are invalidated in the same cycle.
- Reset asserted mid-MD_BUSY or mid-MEM_WAIT: next cycle in RUN, md_cnt 0, counters 0.

## Structure
- Shared package rv32_types:
  - pipe_ctrl_state_t enum {RUN, MEM_WAIT, MD_BUSY}.
  - pipe_ctrl_t struct grouping the five enables, two flushes and pc_redirect.
  - MD_LATENCY default constant.
- Sub-module rv32_perf_counter (CNT_W, clk, rst, inc, value), instantiated twice.

## Test plan
- Reset with all inputs 0: enables 0 and flushes 1 during reset. First cycle after reset: all enables 1, counters 0.
- hazard_stall pulse for 1 cycle: fetch_en=decode_en=0, flush_decoded_buff=1, exec_en=1; stall_cycles becomes 1.
- branch_taken with hazard_stall same cycle: all enables 1, both flushes 1, pc_redirect 1; flush_events becomes 1.
- mem_req_valid=1, mem_req_ready low for 3 cycles then high: 3 frozen cycles, enables 1 on the 4th, state RUN.
- MD_LATENCY=4, muldiv_start held for 4 cycles: frozen 3 cycles, muldiv_done on the 4th, no restart; stall_cycles = 3.
- rst asserted on the 2nd MD_BUSY cycle: next cycle state RUN, muldiv_done never pulses.
